// File: rtl/control_unit.sv
// Hardwired sequencer for the `system` datapath: two-byte fetch into IR, then one or two execute cycles.
// Define CU_BRANCH_EN to build BRA/BNE and the Z flag latch; otherwise ops D and E execute as NOP.
module control_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] IR_out,
    input  logic [3:0]  alu_flags,
    output logic [1:0]  outasel,
    output logic [1:0]  outbsel,
    output logic [1:0]  funsel_IR,
    output logic [1:0]  funsel_arf,
    output logic [1:0]  funsel_rf,
    output logic [3:0]  funsel_alu,
    output logic [3:0]  regsel_rf,
    output logic [3:0]  regsel_arf,
    output logic        wrMEM,
    output logic        csMEM,
    output logic        IR_enable,
    output logic        IR_lh,
    output logic [1:0]  MUXSelA,
    output logic [1:0]  MUXSelB,
    output logic        MUXSelC,
    output logic [2:0]  rf_o1sel,
    output logic [2:0]  rf_o2sel,
    output logic [3:0]  rf_tsel,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH_L, S_FETCH_H, S_EX1, S_EX2, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LD,  OP_ST,  OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOT, OP_LSL, OP_LSR, OP_INC, OP_BRA, OP_BNE, OP_HLT
    } opcode_t;

    state_t     r_state;
    state_t     w_next_state;
    opcode_t    w_op;
    logic [1:0] w_rx;
    logic [1:0] w_rs;
    logic [3:0] w_rx_onehot;
    logic       w_is_alu;
    logic       w_take_branch;
    logic       w_unused_bits;

    assign w_op        = opcode_t'(IR_out[15:12]);
    assign w_rx        = IR_out[11:10];
    assign w_rs        = IR_out[9:8];
    assign w_rx_onehot = 4'b1000 >> w_rx;
    assign w_is_alu    = (IR_out[15:12] >= 4'h4) && (IR_out[15:12] <= 4'hB);

`ifdef CU_BRANCH_EN
    logic r_z;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_z <= 1'b0;
        else if (r_state == S_EX1 && w_is_alu)
            r_z <= alu_flags[3];
    end

    assign w_take_branch = (w_op == OP_BRA) || (w_op == OP_BNE && !r_z);
    assign w_unused_bits = ^{IR_out[7:0], alu_flags[2:0]};
`else
    assign w_take_branch = 1'b0;
    assign w_unused_bits = ^{IR_out[7:0], alu_flags};
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_INIT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_next_state = r_state;
        outasel      = 2'b00;
        outbsel      = 2'b00;
        funsel_IR    = 2'b00;
        funsel_arf   = 2'b00;
        funsel_rf    = 2'b00;
        funsel_alu   = 4'b0000;
        regsel_rf    = 4'b0000;
        regsel_arf   = 4'b0000;
        wrMEM        = 1'b0;
        csMEM        = 1'b1;
        IR_enable    = 1'b0;
        IR_lh        = 1'b0;
        MUXSelA      = 2'b00;
        MUXSelB      = 2'b00;
        MUXSelC      = 1'b0;
        rf_o1sel     = 3'b000;
        rf_o2sel     = 3'b000;
        rf_tsel      = 4'b0000;
        halted       = 1'b0;

        case (r_state)
            S_INIT: begin
                w_next_state = S_FETCH_L;
                regsel_arf   = 4'b1111;
                regsel_rf    = 4'b1111;
                rf_tsel      = 4'b1111;
                IR_enable    = 1'b1;
            end

            S_FETCH_L, S_FETCH_H: begin
                w_next_state = (r_state == S_FETCH_L) ? S_FETCH_H : S_EX1;
                outbsel      = 2'b11;
                csMEM        = 1'b0;
                IR_enable    = 1'b1;
                funsel_IR    = 2'b01;
                IR_lh        = (r_state == S_FETCH_H);
                regsel_arf   = 4'b0001;
                funsel_arf   = 2'b11;
            end

            S_EX1: begin
                if (w_op == OP_LD || w_op == OP_ST)
                    w_next_state = S_EX2;
                else if (w_op == OP_HLT)
                    w_next_state = S_HALT;
                else
                    w_next_state = S_FETCH_L;

                if (w_is_alu) begin
                    rf_o1sel  = {1'b1, w_rx};
                    rf_o2sel  = {1'b1, w_rs};
                    regsel_rf = w_rx_onehot;
                    funsel_rf = 2'b01;
                end

                case (w_op)
                    OP_LDI: begin
                        MUXSelA   = 2'b10;
                        regsel_rf = w_rx_onehot;
                        funsel_rf = 2'b01;
                    end
                    OP_LD, OP_ST: begin
                        MUXSelB    = 2'b10;
                        regsel_arf = 4'b1000;
                        funsel_arf = 2'b01;
                    end
                    OP_ADD: funsel_alu = 4'b0100;
                    OP_SUB: funsel_alu = 4'b0110;
                    OP_AND: funsel_alu = 4'b0111;
                    OP_OR:  funsel_alu = 4'b1000;
                    OP_XOR: funsel_alu = 4'b1010;
                    OP_NOT: funsel_alu = 4'b0010;
                    OP_LSL: funsel_alu = 4'b1011;
                    OP_LSR: funsel_alu = 4'b1100;
                    OP_INC: begin
                        regsel_rf = w_rx_onehot;
                        funsel_rf = 2'b11;
                    end
                    OP_BRA, OP_BNE: begin
                        if (w_take_branch) begin
                            MUXSelB    = 2'b10;
                            regsel_arf = 4'b0001;
                            funsel_arf = 2'b01;
                        end
                    end
                    default: ;
                endcase
            end

            S_EX2: begin
                w_next_state = S_FETCH_L;
                outbsel      = 2'b00;
                csMEM        = 1'b0;
                if (w_op == OP_ST) begin
                    rf_o1sel = {1'b1, w_rx};
                    wrMEM    = 1'b1;
                end else begin
                    MUXSelA   = 2'b01;
                    regsel_rf = w_rx_onehot;
                    funsel_rf = 2'b01;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: w_next_state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-instruction fetch/execute control words plus
// hand-written reset, halt and abandoned-store sequences. Branch expectations follow CU_BRANCH_EN.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] IR_out;
    logic [3:0]  alu_flags;
    logic [1:0]  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf;
    logic [3:0]  funsel_alu, regsel_rf, regsel_arf;
    logic        wrMEM, csMEM, IR_enable, IR_lh;
    logic [1:0]  MUXSelA, MUXSelB;
    logic        MUXSelC;
    logic [2:0]  rf_o1sel, rf_o2sel;
    logic [3:0]  rf_tsel;
    logic        halted;

    control_unit dut (
        .clock(clock), .reset_n(reset_n), .IR_out(IR_out), .alu_flags(alu_flags),
        .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR),
        .funsel_arf(funsel_arf), .funsel_rf(funsel_rf), .funsel_alu(funsel_alu),
        .regsel_rf(regsel_rf), .regsel_arf(regsel_arf), .wrMEM(wrMEM), .csMEM(csMEM),
        .IR_enable(IR_enable), .IR_lh(IR_lh), .MUXSelA(MUXSelA), .MUXSelB(MUXSelB),
        .MUXSelC(MUXSelC), .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel),
        .rf_tsel(rf_tsel), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] outasel, outbsel, funsel_ir, funsel_arf, funsel_rf;
        logic [3:0] funsel_alu, regsel_rf, regsel_arf;
        logic       wr_mem, cs_mem, ir_enable, ir_lh;
        logic [1:0] mux_a, mux_b;
        logic       mux_c;
        logic [2:0] o1, o2;
        logic [3:0] tsel;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        logic [3:0]  flags;
        outs_t       ex1;
        logic        two;
        outs_t       ex2;
    } vec_t;

    outs_t act;
    assign act = {outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu, regsel_rf,
                  regsel_arf, wrMEM, csMEM, IR_enable, IR_lh, MUXSelA, MUXSelB, MUXSelC,
                  rf_o1sel, rf_o2sel, rf_tsel, halted};

    int    n_checks = 0;
    int    n_fail   = 0;
    vec_t  vecs[20];
    int    n_vec    = 0;
    outs_t e_init, e_fl, e_fh, e_halt, e_ld1, e_bra, e_br_or_nop;

    function automatic outs_t dflt();
        outs_t o;
        o        = '0;
        o.cs_mem = 1'b1;
        return o;
    endfunction

    function automatic outs_t alu_word(input logic [2:0] o1, input logic [2:0] o2,
                                       input logic [3:0] rf, input logic [3:0] fn);
        outs_t o;
        o            = dflt();
        o.o1         = o1;
        o.o2         = o2;
        o.regsel_rf  = rf;
        o.funsel_rf  = 2'b01;
        o.funsel_alu = fn;
        return o;
    endfunction

    task automatic add_vec(input logic [15:0] ir, input logic [3:0] flags, input outs_t ex1,
                           input logic two, input outs_t ex2);
        vecs[n_vec] = '{ir: ir, flags: flags, ex1: ex1, two: two, ex2: ex2};
        n_vec++;
    endtask

    task automatic check(input string name, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    task automatic run_vec(input int i);
        check($sformatf("v%0d_fetch_l", i), e_fl);
        tick();
        check($sformatf("v%0d_fetch_h", i), e_fh);
        IR_out    = vecs[i].ir;
        alu_flags = vecs[i].flags;
        tick();
        check($sformatf("v%0d_ex1_%h", i, vecs[i].ir), vecs[i].ex1);
        if (vecs[i].two) begin
            tick();
            check($sformatf("v%0d_ex2_%h", i, vecs[i].ir), vecs[i].ex2);
        end
        tick();
    endtask

    initial begin
        outs_t e;
        reset_n   = 1'b0;
        IR_out    = 16'h0000;
        alu_flags = 4'h0;

        e_init = dflt();
        e_init.regsel_arf = 4'b1111;
        e_init.regsel_rf  = 4'b1111;
        e_init.tsel       = 4'b1111;
        e_init.ir_enable  = 1'b1;

        e_fl = dflt();
        e_fl.outbsel    = 2'b11;
        e_fl.cs_mem     = 1'b0;
        e_fl.ir_enable  = 1'b1;
        e_fl.funsel_ir  = 2'b01;
        e_fl.regsel_arf = 4'b0001;
        e_fl.funsel_arf = 2'b11;
        e_fh            = e_fl;
        e_fh.ir_lh      = 1'b1;

        e_halt        = dflt();
        e_halt.halted = 1'b1;

        e_ld1 = dflt();
        e_ld1.mux_b      = 2'b10;
        e_ld1.regsel_arf = 4'b1000;
        e_ld1.funsel_arf = 2'b01;

        e_bra = dflt();
        e_bra.mux_b      = 2'b10;
        e_bra.regsel_arf = 4'b0001;
        e_bra.funsel_arf = 2'b01;
`ifdef CU_BRANCH_EN
        e_br_or_nop = e_bra;
`else
        e_br_or_nop = dflt();
`endif

        add_vec(16'h0000, 4'h0, dflt(), 1'b0, dflt());                       // NOP
        e = dflt(); e.mux_a = 2'b10; e.regsel_rf = 4'b1000; e.funsel_rf = 2'b01;
        add_vec(16'h102A, 4'h0, e, 1'b0, dflt());                            // LDI R1,2A
        e = dflt(); e.outbsel = 2'b00; e.cs_mem = 1'b0; e.mux_a = 2'b01;
        e.regsel_rf = 4'b0100; e.funsel_rf = 2'b01;
        add_vec(16'h2480, 4'h0, e_ld1, 1'b1, e);                             // LD R2,[80]
        e = dflt(); e.o1 = 3'b110; e.cs_mem = 1'b0; e.wr_mem = 1'b1;
        add_vec(16'h3890, 4'h0, e_ld1, 1'b1, e);                             // ST R3,[90]
        add_vec(16'h4100, 4'h8, alu_word(3'b100, 3'b101, 4'b1000, 4'b0100), 1'b0, dflt()); // ADD, Z=1
        add_vec(16'hE040, 4'h0, dflt(), 1'b0, dflt());                       // BNE not taken
        add_vec(16'h5B00, 4'h0, alu_word(3'b110, 3'b111, 4'b0010, 4'b0110), 1'b0, dflt()); // SUB, Z=0
        e = dflt(); e.mux_a = 2'b10; e.regsel_rf = 4'b0001; e.funsel_rf = 2'b01;
        add_vec(16'h1C55, 4'h8, e, 1'b0, dflt());                            // LDI must not latch Z
        add_vec(16'hE040, 4'h0, e_br_or_nop, 1'b0, dflt());                  // BNE taken
        add_vec(16'h9700, 4'h8, alu_word(3'b101, 3'b111, 4'b0100, 4'b0010), 1'b0, dflt()); // NOT
        add_vec(16'hBC00, 4'h0, alu_word(3'b111, 3'b100, 4'b0001, 4'b1100), 1'b0, dflt()); // LSR
        e = dflt(); e.regsel_rf = 4'b0001; e.funsel_rf = 2'b11;
        add_vec(16'hCC00, 4'h0, e, 1'b0, dflt());                            // INC R4
        add_vec(16'hD040, 4'h8, e_br_or_nop, 1'b0, dflt());                  // BRA
        add_vec(16'h6600, 4'h8, alu_word(3'b101, 3'b110, 4'b0100, 4'b0111), 1'b0, dflt()); // AND, Z=1
        add_vec(16'hE040, 4'h0, dflt(), 1'b0, dflt());                       // BNE not taken
        add_vec(16'h8300, 4'h0, alu_word(3'b100, 3'b111, 4'b1000, 4'b1010), 1'b0, dflt()); // XOR, Z=0
        add_vec(16'hE040, 4'h0, e_br_or_nop, 1'b0, dflt());                  // BNE taken
        add_vec(16'h7100, 4'h0, alu_word(3'b100, 3'b101, 4'b1000, 4'b1000), 1'b0, dflt()); // OR
        add_vec(16'hA900, 4'h0, alu_word(3'b110, 3'b101, 4'b0010, 4'b1011), 1'b0, dflt()); // LSL

        // Reset held, then exactly one INIT cycle after release.
        @(negedge clock);
        #1;
        check("reset_held_init", e_init);
        reset_n = 1'b1;
        #1;
        check("init_after_release", e_init);
        tick();

        for (int i = 0; i < n_vec; i++)
            run_vec(i);

        // HLT: halted from the cycle after EX1, sticky, memory deselected.
        check("hlt_fetch_l", e_fl);
        tick();
        IR_out = 16'hF000;
        tick();
        check("hlt_ex1", dflt());
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("halt_sticky_%0d", k), e_halt);
        end

        // Leave HALT by reset, then abandon a store in EX2 with reset and no clock edge.
        reset_n = 1'b0;
        #1;
        check("halt_reset_init", e_init);
        reset_n = 1'b1;
        tick();
        check("st_fetch_l", e_fl);
        tick();
        IR_out = 16'h3890;
        tick();
        check("st_ex1", e_ld1);
        tick();
        e = dflt(); e.o1 = 3'b110; e.cs_mem = 1'b0; e.wr_mem = 1'b1;
        check("st_ex2_write", e);
        reset_n = 1'b0;
        #1;
        check("st_abort_async", e_init);
        tick();
        check("reset_low_stays_init", e_init);
        reset_n = 1'b1;
        #1;
        check("st_abort_release_init", e_init);
        tick();
        check("fetch_l_after_abort", e_fl);
        tick();
        check("fetch_h_after_abort", e_fh);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
